// File: rtl/axi4_lite_read_arbiter_if.sv
// AXI4-Lite read-only channel bundle (AR + R) between the arbiter and the
// memory-side slave.
interface axi4_lite_read_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport master (
        output arvalid, araddr, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  arvalid, araddr, rready,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_read_arbiter.sv
// Two-requester (IFU / EX) arbiter onto a single AXI4-Lite read port.
// One read in flight at a time; each requester holds one pending request.
module axi4_lite_read_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter bit RR_EN  = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     instr_req,
    input  logic [ADDR_W-1:0]        instr_addr,
    output logic                     instr_finish,
    output logic [DATA_W-1:0]        instr_data,
    output logic                     instr_err,
    input  logic                     ex_req,
    input  logic [ADDR_W-1:0]        ex_addr,
    output logic                     ex_finish,
    output logic [DATA_W-1:0]        ex_data,
    output logic                     ex_err,
    axi4_lite_read_arbiter_if.master m,
    output logic                     busy
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic SLOT_INSTR = 1'b0;
    localparam logic SLOT_EX    = 1'b1;

    state_t            state_reg, state_next;
    logic              owner_reg, owner_next;
    logic              prio_instr_reg, prio_instr_next;
    logic              arvalid_reg, arvalid_next;
    logic              rready_reg, rready_next;
    logic [ADDR_W-1:0] araddr_reg, araddr_next;

    // Slot 0 = INSTR, slot 1 = EX.
    logic [1:0]        req_vec;
    logic [ADDR_W-1:0] req_addr [2];
    logic [1:0]        pend_reg, pend_next;
    logic [ADDR_W-1:0] addr_reg [2];
    logic [ADDR_W-1:0] addr_next [2];
    logic [DATA_W-1:0] data_reg [2];
    logic [DATA_W-1:0] data_next [2];
    logic [1:0]        err_reg, err_next;
    logic [1:0]        finish_reg, finish_next;

    logic              grant_owner;
    logic              done;

    assign req_vec     = {ex_req, instr_req};
    assign req_addr[0] = instr_addr;
    assign req_addr[1] = ex_addr;
    assign done        = (state_reg == DATA) && m.rvalid && rready_reg;

    always_comb begin
        grant_owner = SLOT_INSTR;
        if (pend_reg == 2'b10) begin
            grant_owner = SLOT_EX;
        end else if (pend_reg == 2'b11) begin
            grant_owner = RR_EN ? ~prio_instr_reg : SLOT_EX;
        end
    end

    // A new request is taken when the slot is free or is being freed this cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        logic clear;
        logic take;
        assign clear           = done && (owner_reg == 1'(gi));
        assign take            = req_vec[gi] && (!pend_reg[gi] || clear);
        assign pend_next[gi]   = take ? 1'b1 : (clear ? 1'b0 : pend_reg[gi]);
        assign addr_next[gi]   = take ? req_addr[gi] : addr_reg[gi];
        assign data_next[gi]   = clear ? m.rdata : data_reg[gi];
        assign err_next[gi]    = clear ? (m.rresp != 2'b00) : err_reg[gi];
        assign finish_next[gi] = clear;
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        prio_instr_next = prio_instr_reg;
        arvalid_next    = arvalid_reg;
        rready_next     = rready_reg;
        araddr_next     = araddr_reg;
        unique case (state_reg)
            IDLE: begin
                if (|pend_reg) begin
                    owner_next      = grant_owner;
                    prio_instr_next = grant_owner;
                    araddr_next     = addr_reg[grant_owner];
                    arvalid_next    = 1'b1;
                    state_next      = ADDR;
                end
            end
            ADDR: begin
                if (m.arready) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (m.rvalid) begin
                    rready_next = 1'b0;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            owner_reg      <= SLOT_INSTR;
            prio_instr_reg <= 1'b1;
            arvalid_reg    <= 1'b0;
            rready_reg     <= 1'b0;
            araddr_reg     <= '0;
            pend_reg       <= '0;
            err_reg        <= '0;
            finish_reg     <= '0;
            for (int i = 0; i < 2; i++) begin
                addr_reg[i] <= '0;
                data_reg[i] <= '0;
            end
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            prio_instr_reg <= prio_instr_next;
            arvalid_reg    <= arvalid_next;
            rready_reg     <= rready_next;
            araddr_reg     <= araddr_next;
            pend_reg       <= pend_next;
            err_reg        <= err_next;
            finish_reg     <= finish_next;
            for (int i = 0; i < 2; i++) begin
                addr_reg[i] <= addr_next[i];
                data_reg[i] <= data_next[i];
            end
        end
    end

    assign m.arvalid    = arvalid_reg;
    assign m.araddr     = araddr_reg;
    assign m.rready     = rready_reg;
    assign instr_finish = finish_reg[0];
    assign instr_data   = data_reg[0];
    assign instr_err    = err_reg[0];
    assign ex_finish    = finish_reg[1];
    assign ex_data      = data_reg[1];
    assign ex_err       = err_reg[1];
    assign busy         = (state_reg != IDLE);
endmodule
